// File: rtl/shot_clk_reporter.sv
// Shot-clock status reporter: sends a 9-byte ASCII line "SC:TO S\r\n" into a
// UART TX FIFO when the displayed status changes, on a query, or on a heartbeat.
module shot_clk_reporter #(
    parameter int unsigned HEARTBEAT_CYCLES = 50000000,
    parameter int unsigned CNT_W            = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [3:0]       tens,
    input  logic [3:0]       ones,
    input  logic             running,
    input  logic             expired,
    input  logic             force_rpt,
    input  logic             tx_full,
    output logic             wr_uart,
    output logic [7:0]       w_data,
    output logic             busy,
    output logic [CNT_W-1:0] msg_count
);

    typedef enum logic [1:0] {IDLE, SNAP, SEND} state_t;

    localparam bit          HB_EN   = (HEARTBEAT_CYCLES != 0);
    localparam logic [31:0] HB_LAST = HB_EN ? HEARTBEAT_CYCLES - 1 : 32'd0;

    state_t           state_reg, state_next;
    logic [9:0]       s1_reg, s2_reg, last_sent_reg, snap_reg;
    logic             pending_reg;
    logic [31:0]      hb_cnt_reg;
    logic [3:0]       idx_reg;
    logic [CNT_W-1:0] msg_count_reg;

    logic             stable, change_trig, query_trig, hb_count_en, hb_trig;
    logic [7:0]       digit_chr [2];
    logic [7:0]       state_chr, msg_byte;

    function automatic logic [7:0] digit_ascii(input logic [3:0] d);
        return (d > 4'd9) ? 8'h3F : {4'h3, d};
    endfunction

    // The inputs come from a divided clock domain, so only a word seen twice
    // in a row is trusted. A change seen in SNAP is already being captured.
    assign stable      = (s1_reg == s2_reg);
    assign change_trig = en && stable && (s2_reg != last_sent_reg) && (state_reg != SNAP);
    assign query_trig  = en && force_rpt;
    assign hb_count_en = HB_EN && en && (state_reg == IDLE) && !pending_reg;
    assign hb_trig     = hb_count_en && (hb_cnt_reg == HB_LAST);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_digit
            assign digit_chr[gi] = digit_ascii(snap_reg[gi*4 +: 4]);
        end
    endgenerate

    assign state_chr = snap_reg[9] ? 8'h42 : (snap_reg[8] ? 8'h52 : 8'h48);

    always_comb begin
        msg_byte = 8'h00;
        case (idx_reg)
            4'd0:    msg_byte = 8'h53;
            4'd1:    msg_byte = 8'h43;
            4'd2:    msg_byte = 8'h3A;
            4'd3:    msg_byte = digit_chr[1];
            4'd4:    msg_byte = digit_chr[0];
            4'd5:    msg_byte = 8'h20;
            4'd6:    msg_byte = state_chr;
            4'd7:    msg_byte = 8'h0D;
            4'd8:    msg_byte = 8'h0A;
            default: msg_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        wr_uart    = 1'b0;
        w_data     = 8'h00;
        case (state_reg)
            IDLE: begin
                if (pending_reg) begin
                    state_next = SNAP;
                end
            end
            SNAP: begin
                state_next = SEND;
            end
            SEND: begin
                wr_uart = !tx_full;
                w_data  = msg_byte;
                if (!tx_full && idx_reg == 4'd8) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_reg        <= 10'h3FF;
            s2_reg        <= 10'h3FF;
            last_sent_reg <= 10'h3FF;
            snap_reg      <= 10'h000;
            pending_reg   <= 1'b0;
            hb_cnt_reg    <= 32'd0;
            idx_reg       <= 4'd0;
            msg_count_reg <= '0;
        end else begin
            s1_reg <= {expired, running, tens, ones};
            s2_reg <= s1_reg;

            // A query arriving during SNAP is kept for the following message.
            if (!en) begin
                pending_reg <= 1'b0;
            end else if (state_reg == SNAP) begin
                pending_reg <= query_trig;
            end else if (change_trig || query_trig || hb_trig) begin
                pending_reg <= 1'b1;
            end

            if (!en || state_reg == SNAP) begin
                hb_cnt_reg <= 32'd0;
            end else if (hb_count_en) begin
                hb_cnt_reg <= hb_trig ? 32'd0 : hb_cnt_reg + 32'd1;
            end

            if (state_reg == SNAP) begin
                snap_reg      <= s2_reg;
                last_sent_reg <= s2_reg;
                idx_reg       <= 4'd0;
            end else if (state_reg == SEND && wr_uart) begin
                if (idx_reg == 4'd8) begin
                    idx_reg       <= 4'd0;
                    msg_count_reg <= msg_count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    idx_reg <= idx_reg + 4'd1;
                end
            end
        end
    end

    assign busy      = (state_reg != IDLE);
    assign msg_count = msg_count_reg;

endmodule

// File: tb/tb_shot_clk_reporter.sv
// Self-checking bench for shot_clk_reporter: table of status words with their
// expected ASCII lines, a byte scoreboard, and hand-written corner sequences.
module tb_shot_clk_reporter;

    logic        clk = 1'b0;
    logic        rst, en, en_h, running, expired, force_rpt, tx_full;
    logic [3:0]  tens, ones;
    logic        wr_uart, busy, wr_uart_h, busy_h;
    logic [7:0]  w_data, w_data_h;
    logic [15:0] msg_count, msg_count_h;

    always #5 clk = ~clk;

    shot_clk_reporter #(.HEARTBEAT_CYCLES(0), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .tens(tens), .ones(ones),
        .running(running), .expired(expired), .force_rpt(force_rpt),
        .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data),
        .busy(busy), .msg_count(msg_count)
    );

    shot_clk_reporter #(.HEARTBEAT_CYCLES(100), .CNT_W(16)) dut_hb (
        .clk(clk), .rst(rst), .en(en_h), .tens(tens), .ones(ones),
        .running(running), .expired(expired), .force_rpt(force_rpt),
        .tx_full(tx_full), .wr_uart(wr_uart_h), .w_data(w_data_h),
        .busy(busy_h), .msg_count(msg_count_h)
    );

    typedef struct {
        logic [3:0]  tens;
        logic [3:0]  ones;
        logic        running;
        logic        expired;
        logic [71:0] line;
    } vec_t;

    vec_t        vt [7];
    int          compares   = 0;
    int          mismatches = 0;
    logic [7:0]  exp_q [$];
    int          n_bytes  = 0;
    int          exp_msgs = 0;
    int          cyc      = 0;
    int          h_idx    = 0;
    int          h_starts [$];
    logic [71:0] hb_line  = 72'd0;
    logic [71:0] line17   = 72'h53_43_3A_31_37_20_52_0D_0A;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        compares++;
        if (act !== req) begin
            mismatches++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
        end
    endtask

    task automatic set_inputs(input vec_t v);
        tens    = v.tens;
        ones    = v.ones;
        running = v.running;
        expired = v.expired;
    endtask

    task automatic push_line(input logic [71:0] l);
        for (int k = 0; k < 9; k++) exp_q.push_back(l[71-8*k -: 8]);
    endtask

    task automatic wait_msgs(input string nm);
        int n = 0;
        while (msg_count != exp_msgs[15:0] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_count"}, {16'd0, msg_count}, exp_msgs);
        $display("msg %0d (%s) after %0d cycles", exp_msgs, nm, n);
        repeat (15) @(negedge clk);
        chk({nm, "_idle_count"}, {16'd0, msg_count}, exp_msgs);
        chk({nm, "_queue_left"}, exp_q.size(), 0);
    endtask

    task automatic wait_bytes(input int target, input string nm);
        int n = 0;
        while (n_bytes < target && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n_bytes < target) begin
            compares++;
            mismatches++;
            $display("FAIL %s_timeout: got %0d bytes required %0d", nm, n_bytes, target);
        end
    endtask

    initial begin
        int base;
        int n;
        logic [7:0] e;

        vt[0] = '{4'd2, 4'd4,   1'b1, 1'b0, 72'h53_43_3A_32_34_20_52_0D_0A};
        vt[1] = '{4'd2, 4'd3,   1'b1, 1'b0, 72'h53_43_3A_32_33_20_52_0D_0A};
        vt[2] = '{4'd2, 4'd3,   1'b0, 1'b0, 72'h53_43_3A_32_33_20_48_0D_0A};
        vt[3] = '{4'd0, 4'd0,   1'b1, 1'b1, 72'h53_43_3A_30_30_20_42_0D_0A};
        vt[4] = '{4'd9, 4'hC,   1'b1, 1'b0, 72'h53_43_3A_39_3F_20_52_0D_0A};
        vt[5] = '{4'hA, 4'd5,   1'b0, 1'b0, 72'h53_43_3A_3F_35_20_48_0D_0A};
        vt[6] = '{4'd9, 4'd9,   1'b0, 1'b1, 72'h53_43_3A_39_39_20_42_0D_0A};

        rst = 1'b1; en = 1'b1; en_h = 1'b0; force_rpt = 1'b0; tx_full = 1'b0;
        set_inputs(vt[0]);

        fork
            forever begin
                @(negedge clk);
                cyc++;
                if (!rst && wr_uart) begin
                    n_bytes++;
                    if (exp_q.size() == 0) begin
                        compares++;
                        mismatches++;
                        $display("FAIL unexpected_byte: got 0x%02h required no write", w_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tx_byte", {24'd0, w_data}, {24'd0, e});
                    end
                end
                if (!rst && wr_uart_h) begin
                    if (h_idx == 0) h_starts.push_back(cyc);
                    chk("hb_byte", {24'd0, w_data_h}, {24'd0, hb_line[71-8*h_idx -: 8]});
                    h_idx = (h_idx + 1) % 9;
                end
            end
        join_none

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_wr_uart", {31'd0, wr_uart}, 0);
        chk("rst_w_data", {24'd0, w_data}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_msg_count", {16'd0, msg_count}, 0);
        push_line(vt[0].line);
        @(posedge clk); #1 rst = 1'b0;
        exp_msgs = 1;
        wait_msgs("first");

        // table: each new word gives one line, first write 5 cycles after change
        for (int i = 1; i < 7; i++) begin
            @(posedge clk); #1;
            set_inputs(vt[i]);
            push_line(vt[i].line);
            repeat (5) @(negedge clk);
            chk("lat_snap_wr", {31'd0, wr_uart}, 0);
            chk("lat_snap_busy", {31'd0, busy}, 1);
            @(negedge clk);
            chk("lat_first_wr", {31'd0, wr_uart}, 1);
            exp_msgs++;
            wait_msgs("vec");
        end

        // tx_full stall for 7 cycles after byte 3 accepted
        @(posedge clk); #1;
        set_inputs(vt[1]);
        push_line(vt[1].line);
        base = n_bytes;
        wait_bytes(base + 4, "stall");
        @(posedge clk); #1 tx_full = 1'b1;
        repeat (7) begin
            @(negedge clk);
            chk("stall_wr", {31'd0, wr_uart}, 0);
        end
        @(posedge clk); #1 tx_full = 1'b0;
        exp_msgs++;
        wait_msgs("stall");

        // two query pulses during SEND give exactly one extra line
        @(posedge clk); #1;
        set_inputs(vt[3]);
        push_line(vt[3].line);
        push_line(vt[3].line);
        base = n_bytes;
        wait_bytes(base + 2, "query");
        force_rpt = 1'b1;
        @(posedge clk); #1 force_rpt = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        force_rpt = 1'b1;
        @(posedge clk); #1 force_rpt = 1'b0;
        exp_msgs += 2;
        wait_msgs("query");

        // change during SEND: the 1-cycle glitch is dropped, latest word sent next
        @(posedge clk); #1;
        set_inputs(vt[0]);
        push_line(vt[0].line);
        base = n_bytes;
        wait_bytes(base + 2, "midsend");
        set_inputs(vt[2]);
        @(posedge clk); #1;
        set_inputs(vt[4]);
        push_line(vt[4].line);
        exp_msgs += 2;
        wait_msgs("midsend");

        // en=0 mid-message: line completes, later changes ignored until en=1
        @(posedge clk); #1;
        set_inputs(vt[5]);
        push_line(vt[5].line);
        base = n_bytes;
        wait_bytes(base + 2, "en_off");
        en = 1'b0;
        exp_msgs++;
        wait_msgs("en_off");
        @(posedge clk); #1;
        set_inputs(vt[6]);
        repeat (30) @(negedge clk);
        chk("en_off_quiet", {16'd0, msg_count}, exp_msgs);
        push_line(vt[6].line);
        @(posedge clk); #1 en = 1'b1;
        exp_msgs++;
        wait_msgs("en_on");

        // heartbeat instance: 100 idle cycles + pending + SNAP + 9 bytes = 111
        @(posedge clk); #1;
        tens = 4'd1; ones = 4'd7; running = 1'b1; expired = 1'b0;
        push_line(line17);
        exp_msgs++;
        wait_msgs("hb_setup");
        hb_line = line17;
        h_starts.delete();
        @(posedge clk); #1 en_h = 1'b1;
        n = 0;
        while (msg_count_h != 16'd3 && n < 600) begin @(negedge clk); n++; end
        chk("hb_count3", {16'd0, msg_count_h}, 3);
        chk("hb_starts3", h_starts.size(), 3);
        if (h_starts.size() >= 3) begin
            chk("hb_gap1", h_starts[1] - h_starts[0], 111);
            chk("hb_gap2", h_starts[2] - h_starts[1], 111);
        end
        n = 0;
        while (!(h_starts.size() == 4 && h_idx == 3) && n < 300) begin
            @(negedge clk); #1; n++;
        end
        en_h = 1'b0;
        n = 0;
        while (msg_count_h != 16'd4 && n < 50) begin @(negedge clk); n++; end
        chk("hb_inflight_done", {16'd0, msg_count_h}, 4);
        repeat (250) @(negedge clk);
        chk("hb_off_count", {16'd0, msg_count_h}, 4);
        chk("hb_off_starts", h_starts.size(), 4);
        chk("hb_byte_phase", h_idx, 0);

        // reset in the middle of byte 5
        @(posedge clk); #1;
        set_inputs(vt[0]);
        push_line(vt[0].line);
        base = n_bytes;
        wait_bytes(base + 6, "rst_mid");
        rst = 1'b1;
        #1;
        chk("rst_mid_wr", {31'd0, wr_uart}, 0);
        chk("rst_mid_busy", {31'd0, busy}, 0);
        chk("rst_mid_count", {16'd0, msg_count}, 0);
        chk("rst_mid_hb_count", {16'd0, msg_count_h}, 0);
        exp_q.delete();
        h_idx = 0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        push_line(vt[0].line);
        exp_msgs = 1;
        wait_msgs("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
        $finish;
    end

endmodule

// File: doc/shot_clk_reporter.md
Name: shot_clk_reporter

Overview:
- UART status transmitter for the shot clock. It is the outbound side of the ASCII command link: the board receives 'r'/'s'/'p' commands, and this block sends back status lines.
- It watches the displayed digits and the run/stop/expired state. On a change, on a query pulse, or on a periodic heartbeat, it formats a fixed 9-byte ASCII line.
- It pushes that line byte-by-byte into the uart_top TX FIFO through the wr_uart/w_data/tx_full handshake.

Parameters:
- HEARTBEAT_CYCLES, 50000000, clk cycles between unsolicited reports while idle. 0 disables the heartbeat.
- CNT_W, 16, width of msg_count.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  reporting enable.
- tens  in  4  displayed tens digit (BCD).
- ones  in  4  displayed ones digit (BCD).
- running  in  1  1 = clock counting, 0 = stopped.
- expired  in  1  1 = clock reached 00 and the buzzer flag is set.
- force_rpt  in  1  one-cycle query pulse; requests a report now.
- tx_full  in  1  UART TX FIFO full.
- wr_uart  out  1  FIFO write strobe; a byte is accepted in any cycle where this is high.
- w_data  out  8  byte presented with wr_uart.
- busy  out  1  high while a message is in progress (SNAP or SEND).
- msg_count  out  CNT_W  number of completed messages; wraps to 0 after all-ones.

Behaviour:
- Reset values: wr_uart=0, w_data=0, busy=0, msg_count=0, state=IDLE, pending=0, heartbeat counter=0, last_sent=10'h3FF.
- Input sampling:
  - Status word = {expired, running, tens, ones}, 10 bits.
  - Two-stage register: s1<=word, s2<=s1. The inputs originate on a divided clock.
  - stable = (s1==s2).
- Triggers, evaluated only when en=1. Each sets pending; multiple triggers coalesce into one pending report.
  - Change: stable && s2!=last_sent.
  - Query: force_rpt=1. It is latched even while busy and serviced after the current message.
  - Heartbeat: counter increments in IDLE with en=1 and pending=0. When it reaches HEARTBEAT_CYCLES-1 it sets pending and clears. The counter also clears whenever a message starts.
- en=0: pending cleared, no new triggers, heartbeat counter held at 0. A message already in SEND completes normally.
- First report after reset: last_sent=3FF differs from any legal word, so a report goes out automatically once the inputs are stable and en=1.
- State machine:
  - IDLE: if pending, go to SNAP.
  - SNAP (1 cycle): snap<=s2; last_sent<=s2; pending<=0; idx<=0; go to SEND.
  - SEND:
    - w_data = byte[idx]; wr_uart = !tx_full (combinational from state and tx_full).
    - On a cycle with wr_uart=1, idx increments.
    - When byte 8 is accepted: msg_count+1, go to IDLE.
    - tx_full=1 stalls with idx held; no byte is lost or duplicated.
- Message bytes (from the snapshot; input changes during SEND do not alter the line in flight):
  - byte 0 = 'S' 0x53
  - byte 1 = 'C' 0x43
  - byte 2 = ':' 0x3A
  - byte 3 = tens ASCII, 0x30+tens
  - byte 4 = ones ASCII, 0x30+ones
  - byte 5 = ' ' 0x20
  - byte 6 = state char: 'B' 0x42 if expired, else 'R' 0x52 if running, else 'H' 0x48. expired has priority over running.
  - byte 7 = CR 0x0D
  - byte 8 = LF 0x0A
  - A digit value >9 is sent as '?' 0x3F.
- Latency: a change held on the inputs gives stable at the 2nd edge and pending at the 3rd edge. The first wr_uart=1 appears 5 cycles after the input change when idle and tx_full=0. Unstalled, a message takes 9 consecutive wr_uart cycles.
- A change that occurs during SEND sets pending once stable and is sent as the next message. Intermediate values are not queued; only the latest stable word is reported.
- Simultaneous change, query and heartbeat in one cycle produce a single message.
- rst during SEND: immediate return to the reset state. wr_uart drops the same cycle; the partial line is not completed.

Test Plan:
- Reset release with tens=2, ones=4, running=1, en=1, tx_full=0 -> exactly 9 writes "SC:24 R\r\n" (53 43 3A 32 34 20 52 0D 0A); msg_count=1.
- Step ones 4->3, then running=0, separated by 20 cycles -> two messages, "SC:23 R\r\n" then "SC:23 H\r\n"; msg_count=3.
- tx_full high for 7 cycles after byte 3 is accepted -> wr_uart low for those 7 cycles; byte stream identical to the unstalled case; no duplicate bytes.
- tens=0, ones=0, expired=1, running=1 -> "SC:00 B\r\n". Then force_rpt pulsed twice during that SEND -> exactly one extra identical message.
- HEARTBEAT_CYCLES=100, inputs static -> one message every 100 idle cycles plus message time. en=0 -> no further messages and the in-flight message completes. ones=4'hC -> byte 4 = 0x3F.
- Assert rst at byte 5 of a message -> wr_uart=0 the same cycle; after release, a full fresh message; msg_count restarts from 0.
